// File: rtl/ufm_access_ctrl_pkg.sv
// Shared types for the UFM access controller: sequencer states and UFM opcodes.
package ufm_access_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    UFM_OP_READ  = 2'b00,
    UFM_OP_PROG  = 2'b01,
    UFM_OP_ERASE = 2'b10,
    UFM_OP_ILL   = 2'b11
  } ufm_op_e;

endpackage

// File: rtl/ufm_rr_arb.sv
// Two-way round-robin arbiter; the registered pointer remembers the port granted last.
module ufm_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       take_i,
  output logic       valid_o,
  output logic       sel_o
);

  logic lastGnt_q;

  // On contention the port that was not served last wins; reset favours port 0.
  always_comb begin
    valid_o = |req_i;
    if (&req_i) begin
      sel_o = ~lastGnt_q;
    end else begin
      sel_o = req_i[1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lastGnt_q <= 1'b1;
    end else if (take_i) begin
      lastGnt_q <= sel_o;
    end
  end

endmodule

// File: rtl/ufm_access_ctrl.sv
// Two-port arbiter/sequencer for the ALTUFM parallel interface with per-operation timeout.
// Define UFM_VERIFY_EN to add an automatic read-back check after every program operation.
module ufm_access_ctrl
  import ufm_access_ctrl_pkg::*;
#(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 16,
  parameter int STROBE_CYC = 2,
  parameter int TIMEOUT    = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_req,
  input  logic [1:0]        r0_op,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_gnt,
  output logic              r0_done,
  output logic              r0_err,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic [1:0]        r1_op,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_done,
  output logic              r1_err,
  output logic [DATA_W-1:0] r1_rdata,
  output logic [ADDR_W-1:0] ufm_addr,
  output logic [DATA_W-1:0] ufm_datain,
  output logic              ufm_nread,
  output logic              ufm_nprogram,
  output logic              ufm_nerase,
  input  logic [DATA_W-1:0] ufm_dataout,
  input  logic              ufm_nbusy,
  input  logic              ufm_data_valid,
  output logic              busy
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);
  localparam logic [3:0]       STRB_LAST = 4'(STROBE_CYC);

  state_e            state_q, state_d;
  ufm_op_e           op_q, op_d;
  logic              owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        strbCnt_q, strbCnt_d;
  logic [TMO_W-1:0]  tmoCnt_q, tmoCnt_d;
  logic              seenBusy_q, seenBusy_d;
  logic              verify_q, verify_d;
  logic              nRead_q, nRead_d;
  logic              nProg_q, nProg_d;
  logic              nErase_q, nErase_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [1:0]        done_q, done_d;
  logic [1:0]        err_q, err_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              arbValid, arbSel, arbTake, tmoRun;

  ufm_rr_arb u_arb (
    .clk     (clk),
    .rst     (rst),
    .req_i   ({r1_req, r0_req}),
    .take_i  (arbTake),
    .valid_o (arbValid),
    .sel_o   (arbSel)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    strbCnt_d  = strbCnt_q;
    tmoCnt_d   = tmoCnt_q;
    seenBusy_d = seenBusy_q;
    verify_d   = verify_q;
    nRead_d    = 1'b1;
    nProg_d    = 1'b1;
    nErase_d   = 1'b1;
    gnt_d      = 2'b00;
    done_d     = 2'b00;
    err_d      = 2'b00;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    arbTake    = 1'b0;

    // The timeout window opens on the first strobe-low cycle and covers the whole wait.
    tmoRun = ((state_q == ST_ISSUE) && (strbCnt_q != 4'd0)) ||
             ((state_q == ST_WAIT) && (op_q != UFM_OP_ILL));
    if (tmoRun) begin
      tmoCnt_d = tmoCnt_q + TMO_W'(1);
      if (!ufm_nbusy) begin
        seenBusy_d = 1'b1;
      end
    end

    case (state_q)
      ST_INIT: begin
        if (ufm_nbusy) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (arbValid) begin
          arbTake        = 1'b1;
          owner_d        = arbSel;
          op_d           = arbSel ? ufm_op_e'(r1_op) : ufm_op_e'(r0_op);
          addr_d         = arbSel ? r1_addr : r0_addr;
          wdata_d        = arbSel ? r1_wdata : r0_wdata;
          gnt_d[arbSel]  = 1'b1;
          strbCnt_d      = 4'd0;
          tmoCnt_d       = '0;
          seenBusy_d     = 1'b0;
          verify_d       = 1'b0;
          state_d        = (op_d == UFM_OP_ILL) ? ST_WAIT : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // First ISSUE cycle is address setup with strobes high, then STROBE_CYC low cycles.
        if (strbCnt_q == STRB_LAST) begin
          state_d = ST_WAIT;
        end else begin
          strbCnt_d = strbCnt_q + 4'd1;
          if (verify_q || (op_q == UFM_OP_READ)) begin
            nRead_d = 1'b0;
          end else if (op_q == UFM_OP_PROG) begin
            nProg_d = 1'b0;
          end else begin
            nErase_d = 1'b0;
          end
        end
      end
      ST_WAIT: begin
        if (op_q == UFM_OP_ILL) begin
          done_d[owner_q] = 1'b1;
          err_d[owner_q]  = 1'b1;
          state_d         = ST_RESP;
        end else if (verify_q || (op_q == UFM_OP_READ)) begin
          if (ufm_data_valid) begin
            if (owner_q) begin
              rdata1_d = ufm_dataout;
            end else begin
              rdata0_d = ufm_dataout;
            end
            done_d[owner_q] = 1'b1;
            err_d[owner_q]  = verify_q && (ufm_dataout != wdata_q);
            state_d         = ST_RESP;
          end
        end else if (seenBusy_q && ufm_nbusy) begin
`ifdef UFM_VERIFY_EN
          if (op_q == UFM_OP_PROG) begin
            verify_d   = 1'b1;
            strbCnt_d  = 4'd0;
            tmoCnt_d   = '0;
            seenBusy_d = 1'b0;
            state_d    = ST_ISSUE;
          end else begin
            done_d[owner_q] = 1'b1;
            state_d         = ST_RESP;
          end
`else
          done_d[owner_q] = 1'b1;
          state_d         = ST_RESP;
`endif
        end
      end
      ST_RESP: begin
        verify_d = 1'b0;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase

    // A stalled flash may still be busy, so a timeout returns to INIT rather than IDLE.
    if (tmoRun && (tmoCnt_q == TMO_LAST) && (state_d == state_q)) begin
      done_d[owner_q] = 1'b1;
      err_d[owner_q]  = 1'b1;
      nRead_d         = 1'b1;
      nProg_d         = 1'b1;
      nErase_d        = 1'b1;
      state_d         = ST_INIT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_INIT;
      op_q       <= UFM_OP_READ;
      owner_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      strbCnt_q  <= 4'd0;
      tmoCnt_q   <= '0;
      seenBusy_q <= 1'b0;
      verify_q   <= 1'b0;
      nRead_q    <= 1'b1;
      nProg_q    <= 1'b1;
      nErase_q   <= 1'b1;
      gnt_q      <= 2'b00;
      done_q     <= 2'b00;
      err_q      <= 2'b00;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      strbCnt_q  <= strbCnt_d;
      tmoCnt_q   <= tmoCnt_d;
      seenBusy_q <= seenBusy_d;
      verify_q   <= verify_d;
      nRead_q    <= nRead_d;
      nProg_q    <= nProg_d;
      nErase_q   <= nErase_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

  assign r0_gnt       = gnt_q[0];
  assign r1_gnt       = gnt_q[1];
  assign r0_done      = done_q[0];
  assign r1_done      = done_q[1];
  assign r0_err       = err_q[0];
  assign r1_err       = err_q[1];
  assign r0_rdata     = rdata0_q;
  assign r1_rdata     = rdata1_q;
  assign ufm_addr     = addr_q;
  assign ufm_datain   = wdata_q;
  assign ufm_nread    = nRead_q;
  assign ufm_nprogram = nProg_q;
  assign ufm_nerase   = nErase_q;
  assign busy         = (state_q != ST_IDLE);

endmodule
